// File: rtl/register_file_scoreboard.sv
// Register file R0..R14 with write-through read bypass, a debug read port and a per-register
// pending-write scoreboard that drives the src1/src2 hazard flags.
module register_file_scoreboard #(
    parameter int REGISTER_FILE_LEN         = 32,
    parameter int REGISTER_FILE_ADDRESS_LEN = 4,
    parameter int REG_COUNT                 = 15,
    parameter int PEND_W                    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wb_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] wb_dest,
    input  logic [REGISTER_FILE_LEN-1:0]         wb_value,
    input  logic                                 issue_en,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] issue_dest,
    input  logic                                 flush,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src1,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] src2,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dbg_addr,
    output logic [REGISTER_FILE_LEN-1:0]         reg1,
    output logic [REGISTER_FILE_LEN-1:0]         reg2,
    output logic [REGISTER_FILE_LEN-1:0]         dbg_data,
    output logic                                 hazard1,
    output logic                                 hazard2,
    output logic [15:0]                          wb_count
);

    localparam int A = REGISTER_FILE_ADDRESS_LEN;
    localparam logic [A-1:0]      REG_LIMIT = A'(REG_COUNT);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    logic [REGISTER_FILE_LEN-1:0] regs_q [REG_COUNT];
    logic [REGISTER_FILE_LEN-1:0] regs_d [REG_COUNT];
    logic [PEND_W-1:0]            pend_q [REG_COUNT];
    logic [PEND_W-1:0]            pend_d [REG_COUNT];
    logic [15:0]                  wb_count_q;
    logic [15:0]                  wb_count_d;

    logic wb_ok;
    logic issue_ok;
    logic src1_ok;
    logic src2_ok;
    logic dbg_ok;

    assign wb_ok    = wb_en && (wb_dest < REG_LIMIT);
    assign issue_ok = issue_en && (issue_dest < REG_LIMIT);
    assign src1_ok  = src1 < REG_LIMIT;
    assign src2_ok  = src2 < REG_LIMIT;
    assign dbg_ok   = dbg_addr < REG_LIMIT;

    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wb_ok) begin
            regs_d[wb_dest] = wb_value;
            if (wb_count_q != 16'hFFFF) begin
                wb_count_d = wb_count_q + 16'd1;
            end
        end
    end

    // Issue and retire on the same register cancel; flush wins over both.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            logic inc;
            logic dec;
            inc       = issue_ok && (issue_dest == A'(i));
            dec       = wb_ok && (wb_dest == A'(i));
            pend_d[i] = pend_q[i];
            if (flush) begin
                pend_d[i] = '0;
            end else if (inc && !dec && (pend_q[i] != PEND_MAX)) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q     <= '{default: '0};
            pend_q     <= '{default: '0};
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            wb_count_q <= wb_count_d;
        end
    end

    logic [PEND_W-1:0] pend1;
    logic [PEND_W-1:0] pend2;
    logic              byp1;
    logic              byp2;

    always_comb begin
        pend1    = '0;
        pend2    = '0;
        reg1     = '0;
        reg2     = '0;
        dbg_data = '0;
        byp1     = wb_ok && (wb_dest == src1);
        byp2     = wb_ok && (wb_dest == src2);
        if (src1_ok) begin
            pend1 = pend_q[src1];
            reg1  = byp1 ? wb_value : regs_q[src1];
        end
        if (src2_ok) begin
            pend2 = pend_q[src2];
            reg2  = byp2 ? wb_value : regs_q[src2];
        end
        if (dbg_ok) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    // A final outstanding write retiring this cycle is covered by the bypass.
    assign hazard1  = (pend1 != '0) && !(byp1 && (pend1 == PEND_ONE));
    assign hazard2  = (pend2 != '0) && !(byp2 && (pend2 == PEND_ONE));
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: the driver pushes hand-computed expectations
// into a queue, a separate monitor pops and compares them at each sample strobe.
module tb_register_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_dest = '0;
    logic        flush = 1'b0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] dbg_data;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] wb_count;

    int total = 0;
    int bad   = 0;
    logic smp = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
        logic        h1;
        logic        h2;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    register_file_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .flush      (flush),
        .src1       (src1),
        .src2       (src2),
        .dbg_addr   (dbg_addr),
        .reg1       (reg1),
        .reg2       (reg2),
        .dbg_data   (dbg_data),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(smp);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor_underflow actual=0 required=1");
            end else begin
                e = exp_q.pop_front();
                chk(e.name, "reg1", reg1, e.r1);
                chk(e.name, "reg2", reg2, e.r2);
                chk(e.name, "dbg", dbg_data, e.dbg);
                chk(e.name, "hz1", {31'd0, hazard1}, {31'd0, e.h1});
                chk(e.name, "hz2", {31'd0, hazard2}, {31'd0, e.h2});
                chk(e.name, "cnt", {16'd0, wb_count}, {16'd0, e.cnt});
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, then post the expectation mid-cycle.
    task automatic step(input string n,
                        input logic we, input logic [3:0] wd, input logic [31:0] wv,
                        input logic ie, input logic [3:0] id, input logic fl,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] da,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ed,
                        input logic eh1, input logic eh2, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        wb_en = we; wb_dest = wd; wb_value = wv;
        issue_en = ie; issue_dest = id; flush = fl;
        src1 = s1; src2 = s2; dbg_addr = da;
        #1;
        e.name = n; e.r1 = e1; e.r2 = e2; e.dbg = ed; e.h1 = eh1; e.h2 = eh2; e.cnt = ec;
        exp_q.push_back(e);
        smp = ~smp;
    endtask

    task automatic idle();
        wb_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
        wb_dest = '0; wb_value = '0; issue_dest = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        rst = 1'b1;
        //    name            we  wd     wv           ie  id     fl  s1     s2     da     reg1         reg2         dbg          h1 h2 cnt
        step("reset",         0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd3,  4'd14, 4'd0,  32'h0,       32'h0,       32'h0,       0, 0, 16'd0);
        step("wb5_bypass",    1, 4'd5,  32'hDEADBEEF, 0, 4'd0,  0, 4'd5,  4'd14, 4'd5,  32'hDEADBEEF,32'h0,       32'h0,       0, 0, 16'd0);
        step("dbg5",          0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd5,  4'd0,  4'd5,  32'hDEADBEEF,32'h0,       32'hDEADBEEF,0, 0, 16'd1);
        step("issue7_a",      0, 4'd0,  32'h0,        1, 4'd7,  0, 4'd7,  4'd5,  4'd7,  32'h0,       32'hDEADBEEF,32'h0,       0, 0, 16'd1);
        step("issue7_b",      0, 4'd0,  32'h0,        1, 4'd7,  0, 4'd7,  4'd5,  4'd7,  32'h0,       32'hDEADBEEF,32'h0,       1, 0, 16'd1);
        step("retire7_a",     1, 4'd7,  32'h11111111, 0, 4'd0,  0, 4'd7,  4'd7,  4'd7,  32'h11111111,32'h11111111,32'h0,       1, 1, 16'd1);
        step("retire7_b",     1, 4'd7,  32'h22222222, 0, 4'd0,  0, 4'd7,  4'd5,  4'd7,  32'h22222222,32'hDEADBEEF,32'h11111111,0, 0, 16'd2);
        step("after7",        0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd7,  4'd5,  4'd7,  32'h22222222,32'hDEADBEEF,32'h22222222,0, 0, 16'd3);
        step("issue2",        0, 4'd0,  32'h0,        1, 4'd2,  0, 4'd2,  4'd7,  4'd2,  32'h0,       32'h22222222,32'h0,       0, 0, 16'd3);
        step("iss_ret2",      1, 4'd2,  32'h33333333, 1, 4'd2,  0, 4'd2,  4'd2,  4'd2,  32'h33333333,32'h33333333,32'h0,       0, 0, 16'd3);
        step("pend2_persist", 0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd2,  4'd7,  4'd2,  32'h33333333,32'h22222222,32'h33333333,1, 0, 16'd4);
        step("wb15",          1, 4'd15, 32'h1234,     0, 4'd0,  0, 4'd15, 4'd15, 4'd15, 32'h0,       32'h0,       32'h0,       0, 0, 16'd4);
        step("after15",       0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd15, 4'd2,  4'd5,  32'h0,       32'h33333333,32'hDEADBEEF,0, 1, 16'd4);
        step("issue4_a",      0, 4'd0,  32'h0,        1, 4'd4,  0, 4'd4,  4'd2,  4'd4,  32'h0,       32'h33333333,32'h0,       0, 1, 16'd4);
        step("issue4_b",      0, 4'd0,  32'h0,        1, 4'd4,  0, 4'd4,  4'd2,  4'd4,  32'h0,       32'h33333333,32'h0,       1, 1, 16'd4);
        step("flush_iss4",    1, 4'd4,  32'h44444444, 1, 4'd4,  1, 4'd4,  4'd2,  4'd4,  32'h44444444,32'h33333333,32'h0,       1, 1, 16'd4);
        step("post_flush",    0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd4,  4'd2,  4'd4,  32'h44444444,32'h33333333,32'h44444444,0, 0, 16'd5);
        // Four issues to R9 must saturate at 3, so exactly three retires clear it.
        step("issue9_1",      0, 4'd0,  32'h0,        1, 4'd9,  0, 4'd9,  4'd4,  4'd9,  32'h0,       32'h44444444,32'h0,       0, 0, 16'd5);
        step("issue9_2",      0, 4'd0,  32'h0,        1, 4'd9,  0, 4'd9,  4'd4,  4'd9,  32'h0,       32'h44444444,32'h0,       1, 0, 16'd5);
        step("issue9_3",      0, 4'd0,  32'h0,        1, 4'd9,  0, 4'd9,  4'd4,  4'd9,  32'h0,       32'h44444444,32'h0,       1, 0, 16'd5);
        step("issue9_4",      0, 4'd0,  32'h0,        1, 4'd9,  0, 4'd9,  4'd4,  4'd9,  32'h0,       32'h44444444,32'h0,       1, 0, 16'd5);
        step("retire9_1",     1, 4'd9,  32'h9,        0, 4'd0,  0, 4'd9,  4'd4,  4'd9,  32'h9,       32'h44444444,32'h0,       1, 0, 16'd5);
        step("retire9_2",     1, 4'd9,  32'h9,        0, 4'd0,  0, 4'd9,  4'd4,  4'd9,  32'h9,       32'h44444444,32'h9,       1, 0, 16'd6);
        step("retire9_3",     1, 4'd9,  32'h9,        0, 4'd0,  0, 4'd9,  4'd4,  4'd9,  32'h9,       32'h44444444,32'h9,       0, 0, 16'd7);
        step("after9",        0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd9,  4'd4,  4'd9,  32'h9,       32'h44444444,32'h9,       0, 0, 16'd8);
        step("issue9_pre",    0, 4'd0,  32'h0,        1, 4'd9,  0, 4'd6,  4'd9,  4'd9,  32'h0,       32'h9,       32'h9,       0, 0, 16'd8);
        step("wb6_pre_rst",   1, 4'd6,  32'h66666666, 0, 4'd0,  0, 4'd6,  4'd9,  4'd9,  32'h66666666,32'h9,       32'h9,       0, 1, 16'd8);
        #2;
        rst = 1'b0;
        #1;
        idle();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst",      0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd6,  4'd9,  4'd9,  32'h0,       32'h0,       32'h0,       0, 0, 16'd0);
        step("post_rst_b",    0, 4'd0,  32'h0,        0, 4'd0,  0, 4'd5,  4'd7,  4'd2,  32'h0,       32'h0,       32'h0,       0, 0, 16'd0);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
